// File: rtl/lane_slice_pkg.sv
//------------------------------------------------------------------------------
// lane_slice_pkg
//   Shared defaults and the per-lane configuration record for lane_slice_fifo.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lane_slice_pkg;

  localparam int LANES_DEF  = 3;
  localparam int LANE_W_DEF = 12;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic en;
    logic inv;
  } lane_cfg_t;

  localparam lane_cfg_t LANE_CFG_RESET = '{en: 1'b1, inv: 1'b0};

endpackage : lane_slice_pkg

`default_nettype wire

// File: rtl/lane_slice_fifo_xform.sv
//------------------------------------------------------------------------------
// lane_xform
//   Per-lane write-side transform: zero a disabled lane, optionally invert it.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lane_xform
  import lane_slice_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] lane_i,
  input  lane_cfg_t         cfg_i,
  output logic [LANE_W-1:0] lane_o
);

  always_comb begin
    lane_o = '0;
    if (cfg_i.en) begin
      lane_o = cfg_i.inv ? ~lane_i : lane_i;
    end
  end

endmodule : lane_xform

`default_nettype wire

// File: rtl/lane_slice_fifo.sv
//------------------------------------------------------------------------------
// lane_slice_fifo
//   Synchronous FIFO that applies a per-lane enable/invert transform on write.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lane_slice_fifo
  import lane_slice_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*LANE_W-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*LANE_W-1:0]      out_data,
  input  logic                         cfg_load,
  input  logic [LANES-1:0]             cfg_lane_en,
  input  logic [LANES-1:0]             cfg_lane_inv,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         cfg_err
);

  localparam int W  = LANES * LANE_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q,  count_d;
  lane_cfg_t [LANES-1:0]   cfg_q,    cfg_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [W-1:0]            mem_q [DEPTH];

  logic [W-1:0]            w_xform;
  logic                    w_push;
  logic                    w_pop;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      lane_xform #(
        .LANE_W (LANE_W)
      ) u_xform (
        .lane_i (in_data[k*LANE_W +: LANE_W]),
        .cfg_i  (cfg_q[k]),
        .lane_o (w_xform[k*LANE_W +: LANE_W])
      );
    end
  endgenerate

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cfg_d     = cfg_q;
    cfg_err_d = cfg_err_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Config may only change while nothing is stored or being stored, so every
    // entry is transformed under exactly one configuration.
    if (cfg_load) begin
      if ((count_q == '0) && !w_push) begin
        for (int k = 0; k < LANES; k++) begin
          cfg_d[k].en  = cfg_lane_en[k];
          cfg_d[k].inv = cfg_lane_inv[k];
        end
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cfg_q     <= {LANES{LANE_CFG_RESET}};
      cfg_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cfg_q     <= cfg_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_xform;
    end
  end

  // Gated by out_valid so reset forces zero without clearing storage.
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign cfg_err  = cfg_err_q;

endmodule : lane_slice_fifo

`default_nettype wire

// File: tb/tb_lane_slice_fifo.sv
//------------------------------------------------------------------------------
// tb_lane_slice_fifo
//   Directed scoreboard bench for lane_slice_fifo at default parameters.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lane_slice_fifo;

  localparam int LANES  = 3;
  localparam int LANE_W = 12;
  localparam int DEPTH  = 4;
  localparam int W      = LANES * LANE_W;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic             cfg_load;
  logic [LANES-1:0] cfg_lane_en;
  logic [LANES-1:0] cfg_lane_inv;
  logic [2:0]       count;
  logic             cfg_err;

  int tests_run;
  int tests_failed;

  logic [W-1:0]     sb[$];
  logic [LANES-1:0] m_en;
  logic [LANES-1:0] m_inv;
  logic             m_err;

  lane_slice_fifo #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .cfg_load     (cfg_load),
    .cfg_lane_en  (cfg_lane_en),
    .cfg_lane_inv (cfg_lane_inv),
    .count        (count),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] xf(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      if (m_en[k]) begin
        r[k*LANE_W +: LANE_W] = m_inv[k] ? ~d[k*LANE_W +: LANE_W] : d[k*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_en  = '1;
    m_inv = '0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] exp_data;
    exp_data = (sb.size() != 0) ? sb[0] : '0;
    chk({tag, ".count"},     64'(count),     64'(sb.size()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(sb.size() != 0));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(sb.size() != DEPTH));
    chk({tag, ".cfg_err"},   64'(cfg_err),   64'(m_err));
    chk({tag, ".out_data"},  64'(out_data),  64'(exp_data));
  endtask

  // Called at a falling edge: checks the settled state, drives one cycle,
  // updates the model, and returns at the next falling edge.
  task automatic cycle(input string tag, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic cl,
                       input logic [LANES-1:0] en, input logic [LANES-1:0] inv);
    int  sz;
    logic push, pop;
    check_outputs(tag);
    in_valid     = iv;
    in_data      = d;
    out_ready    = ordy;
    cfg_load     = cl;
    cfg_lane_en  = en;
    cfg_lane_inv = inv;
    sz   = sb.size();
    push = iv && (sz != DEPTH);
    pop  = ordy && (sz != 0);
    if (pop)  void'(sb.pop_front());
    if (push) sb.push_back(xf(d));
    if (cl) begin
      if (sz == 0 && !push) begin
        m_en  = en;
        m_inv = inv;
      end else begin
        m_err = 1'b1;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cfg_load  = 1'b0;
  endtask

  task automatic push_w(input string tag, input logic [W-1:0] d);
    cycle(tag, 1'b1, d, 1'b0, 1'b0, '1, '0);
  endtask

  task automatic pop_w(input string tag);
    cycle(tag, 1'b0, '0, 1'b1, 1'b0, '1, '0);
  endtask

  initial begin
    logic [W-1:0] d;
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    cfg_load     = 1'b0;
    cfg_lane_en  = '1;
    cfg_lane_inv = '0;
    model_reset();

    #1;
    check_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic 1-cycle latency with default config
    push_w("r036_push", 36'h0ABCDEF12);
    chk("r036_data", 64'(out_data), 64'h0ABCDEF12);
    chk("r036_count", 64'(count), 64'd1);
    pop_w("r036_pop");

    // Pop on empty is ignored
    pop_w("empty_pop");

    // Lane disable + invert
    cycle("r037_cfg", 1'b0, '0, 1'b0, 1'b1, 3'b101, 3'b001);
    push_w("r037_push", 36'h123456789);
    chk("r037_data", 64'(out_data), 64'h123000876);
    pop_w("r037_pop");
    cycle("restore_cfg", 1'b0, '0, 1'b0, 1'b1, 3'b111, 3'b000);

    // Fill, overflow attempt, then pop/push interplay
    for (int i = 0; i < 4; i++) begin
      push_w("r038_fill", W'(36'h100000000 + i * 36'h010101));
    end
    chk("r038_full_ready", 64'(in_ready), 64'd0);
    push_w("r038_drop", 36'hFFFFFFFFF);
    cycle("r038_full_pop", 1'b1, 36'hEEEEEEEEE, 1'b1, 1'b0, '1, '0);
    cycle("r038_poppush", 1'b1, 36'h0DDDDDDDD, 1'b1, 1'b0, '1, '0);
    push_w("r038_refill", 36'h0CCCCCCCC);
    for (int i = 0; i < 4; i++) pop_w("r038_drain");

    // Rejected config load leaves config and stored words intact
    for (int i = 0; i < 3; i++) push_w("r039_fill", W'(36'h0A5A5A5A5 ^ i));
    cycle("r039_cfg", 1'b0, '0, 1'b0, 1'b1, 3'b000, 3'b111);
    chk("r039_err", 64'(cfg_err), 64'd1);
    push_w("r039_push", 36'h987654321);
    for (int i = 0; i < 4; i++) pop_w("r039_drain");

    // Pointer wrap with random data, overlapping push/pop
    for (int i = 0; i < 10; i++) begin
      d = {$urandom, $urandom};
      cycle("r040_run", 1'b1, d, (sb.size() >= 2), 1'b0, '1, '0);
    end
    while (sb.size() != 0) pop_w("r040_drain");
    chk("r040_count", 64'(count), 64'd0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push_w("r041_fill", W'(36'h111111111 * (i + 1)));
    cycle("r041_cfgerr", 1'b0, '0, 1'b0, 1'b1, 3'b000, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("r041_async");
    @(negedge clk);
    rst = 1'b0;

    // Config load coinciding with a push on an empty FIFO is rejected
    cycle("cfg_push", 1'b1, 36'h0F0F0F0F0, 1'b0, 1'b1, 3'b000, 3'b111);
    chk("cfg_push_err", 64'(cfg_err), 64'd1);
    chk("cfg_push_data", 64'(out_data), 64'h0F0F0F0F0);
    push_w("cfg_push2", 36'h0000FFF00);
    pop_w("cfg_push_pop1");
    pop_w("cfg_push_pop2");
    check_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule : tb_lane_slice_fifo

`default_nettype wire
